addr_gen_ctrl: RTL

ADDR_GEN_CTRL -- requirements
Module: addr_gen_ctrl

---
 rtl/addr_gen_pkg.sv | 12 +
 rtl/addr_gen_2d_cnt.sv | 49 ++++
 rtl/addr_gen_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/addr_gen_pkg.sv
// Shared definitions for the 2D address generator: state encoding and default width.
package addr_gen_pkg;

  localparam int unsigned AddrWDefault = 32;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/addr_gen_2d_cnt.sv
// Row-major x/y index counters for the 2D scan; flags the end of a row and the final element.
module addr_gen_2d_cnt #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] y_max,
  output logic              wrap,
  output logic              last
);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic              y_end;

  assign wrap  = (x_q == x_max);
  assign y_end = (y_q == y_max);
  assign last  = wrap && y_end;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (wrap) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/addr_gen_ctrl.sv
// 2D strided address generator: latches a scan configuration on start and emits one
// address per accepted handshake in row-major order.
module addr_gen_ctrl
  import addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] y_max,
  input  logic [15:0]       x_stride,
  input  logic [ADDR_W-1:0] y_stride,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] x_max_q, x_max_d;
  logic [ADDR_W-1:0] y_max_q, y_max_d;
  logic [ADDR_W-1:0] y_stride_q, y_stride_d;
  logic [15:0]       x_stride_q, x_stride_d;

  logic cnt_clear, cnt_step;
  logic x_wrap, xy_last;
  logic xfer;

  assign xfer = (state_q == StRun) && addr_ready;

  addr_gen_2d_cnt #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .step  (cnt_step),
    .x_max (x_max_q),
    .y_max (y_max_q),
    .wrap  (x_wrap),
    .last  (xy_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    x_max_d    = x_max_q;
    y_max_d    = y_max_q;
    x_stride_d = x_stride_q;
    y_stride_d = y_stride_q;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          x_max_d    = x_max;
          y_max_d    = y_max;
          x_stride_d = x_stride;
          y_stride_d = y_stride;
          addr_d     = base;
          row_base_d = base;
          cnt_clear  = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        cnt_step = xfer;
        if (xfer) begin
          if (xy_last) begin
            state_d = StDone;
          end else if (x_wrap) begin
            // Next row starts from the row base, not from the last x address.
            row_base_d = row_base_q + y_stride_q;
            addr_d     = row_base_d;
          end else begin
            addr_d = addr_q + ADDR_W'(x_stride_q);
          end
        end
        if (abort) begin
          state_d = StIdle;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      row_base_q <= '0;
      x_max_q    <= '0;
      y_max_q    <= '0;
      x_stride_q <= '0;
      y_stride_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      x_max_q    <= x_max_d;
      y_max_q    <= y_max_d;
      x_stride_q <= x_stride_d;
      y_stride_q <= y_stride_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == StRun);
  assign busy       = (state_q == StRun);
  assign addr_last  = (state_q == StRun) && xy_last;
  assign done       = (state_q == StDone);

endmodule
